// File: rtl/pixel_stream_packer_if.sv
// rtl/pixel_stream_packer_if.sv - pixel beat input and video stream output bundle
// The packer takes the slave view; the generator/sink environment takes the master view.
interface pixel_stream_packer_if #(
  parameter int DATA_WIDTH = 32,
  parameter int RBG_SIZE   = 24
);
  logic                  in_valid;
  logic [DATA_WIDTH-1:0] in_xpixel;
  logic [DATA_WIDTH-1:0] in_ypixel;
  logic [RBG_SIZE-1:0]   in_colour;
  logic                  in_ready;
  logic [RBG_SIZE-1:0]   out_data;
  logic                  out_sof;
  logic                  out_eol;
  logic                  out_valid;
  logic                  out_ready;

  modport master (
    output in_valid, in_xpixel, in_ypixel, in_colour, out_ready,
    input  in_ready, out_data, out_sof, out_eol, out_valid
  );

  modport slave (
    input  in_valid, in_xpixel, in_ypixel, in_colour, out_ready,
    output in_ready, out_data, out_sof, out_eol, out_valid
  );
endinterface

// File: rtl/pixel_stream_packer.sv
// rtl/pixel_stream_packer.sv - buffers pixel beats and re-emits them with sof/eol markers
// Also checks raster continuity and counts emitted frames.
module pixel_stream_packer #(
  parameter int DATA_WIDTH    = 32,
  parameter int RBG_SIZE      = 24,
  parameter int SCREEN_WIDTH  = 640,
  parameter int SCREEN_HEIGHT = 480,
  parameter int FIFO_DEPTH    = 4
) (
  input  logic                  clk,
  input  logic                  reset_n,
  pixel_stream_packer_if.slave  pix,
  input  logic                  clear_err,
  output logic                  overflow_err,
  output logic                  sync_err,
  output logic [15:0]           frame_count
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam int EW = RBG_SIZE + 2;

  localparam logic [CW-1:0]         DEPTH_C = CW'(FIFO_DEPTH);
  localparam logic [CW-1:0]         SLACK_C = CW'(FIFO_DEPTH - 2);
  localparam logic [CW-1:0]         CNT_ONE = CW'(1);
  localparam logic [AW-1:0]         PTR_ONE = AW'(1);
  localparam logic [DATA_WIDTH-1:0] X_LAST  = DATA_WIDTH'(SCREEN_WIDTH - 1);
  localparam logic [DATA_WIDTH-1:0] Y_LAST  = DATA_WIDTH'(SCREEN_HEIGHT - 1);
  localparam logic [DATA_WIDTH-1:0] D_ONE   = DATA_WIDTH'(1);

  logic [EW-1:0]         mem [FIFO_DEPTH];
  logic [AW-1:0]         wr_ptr;
  logic [AW-1:0]         rd_ptr;
  logic [CW-1:0]         count;
  logic [CW-1:0]         count_next;
  logic [EW-1:0]         head;
  logic [DATA_WIDTH-1:0] exp_x;
  logic [DATA_WIDTH-1:0] exp_y;
  logic                  full;
  logic                  rd_en;
  logic                  wr_en;
  logic                  drop;
  logic                  in_sof;
  logic                  in_eol;
  logic                  coord_err;

  assign head          = mem[rd_ptr];
  assign pix.out_valid = (count != '0);
  assign full          = (count == DEPTH_C);
  assign rd_en         = pix.out_valid && pix.out_ready;
  // A read in the same cycle frees the slot, so a full FIFO still accepts the write.
  assign wr_en         = pix.in_valid && (!full || rd_en);
  assign drop          = pix.in_valid && full && !rd_en;
  assign in_sof        = (pix.in_xpixel == '0) && (pix.in_ypixel == '0);
  assign in_eol        = (pix.in_xpixel == X_LAST);
  assign coord_err     = wr_en && ((pix.in_xpixel != exp_x) || (pix.in_ypixel != exp_y));

  assign pix.out_data  = pix.out_valid ? head[EW-1:2] : '0;
  assign pix.out_sof   = pix.out_valid ? head[1] : 1'b0;
  assign pix.out_eol   = pix.out_valid ? head[0] : 1'b0;

  always_comb begin
    count_next = count;
    if (wr_en && !rd_en) begin
      count_next = count + CNT_ONE;
    end else if (rd_en && !wr_en) begin
      count_next = count - CNT_ONE;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_ptr] <= {pix.in_colour, in_sof, in_eol};
    end
  end

  // in_ready keeps one slot spare for the beat the generator already has in flight.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      count        <= '0;
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      pix.in_ready <= 1'b0;
      frame_count  <= '0;
    end else begin
      count        <= count_next;
      pix.in_ready <= (count_next <= SLACK_C);
      if (wr_en) begin
        wr_ptr <= wr_ptr + PTR_ONE;
      end
      if (rd_en) begin
        rd_ptr <= rd_ptr + PTR_ONE;
        if (head[1]) begin
          frame_count <= frame_count + 16'd1;
        end
      end
    end
  end

  // The checker always resynchronises to the received coordinate, good or bad.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      exp_x        <= '0;
      exp_y        <= '0;
      overflow_err <= 1'b0;
      sync_err     <= 1'b0;
    end else begin
      overflow_err <= (overflow_err && !clear_err) || drop;
      sync_err     <= (sync_err && !clear_err) || coord_err;
      if (wr_en) begin
        if (pix.in_xpixel == X_LAST) begin
          exp_x <= '0;
          exp_y <= (pix.in_ypixel >= Y_LAST) ? '0 : pix.in_ypixel + D_ONE;
        end else begin
          exp_x <= pix.in_xpixel + D_ONE;
          exp_y <= pix.in_ypixel;
        end
      end
    end
  end
endmodule

// File: tb/tb_pixel_stream_packer.sv
// tb/tb_pixel_stream_packer.sv - queue-model bench for pixel_stream_packer
// Uses a reduced 16x8 screen so whole frames fit in a short run.
module tb_pixel_stream_packer;
  localparam int DW    = 32;
  localparam int CWID  = 24;
  localparam int SW    = 16;
  localparam int SH    = 8;
  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        clear_err = 1'b0;
  logic        overflow_err;
  logic        sync_err;
  logic [15:0] frame_count;

  pixel_stream_packer_if #(.DATA_WIDTH(DW), .RBG_SIZE(CWID)) bus ();

  pixel_stream_packer #(
    .DATA_WIDTH(DW), .RBG_SIZE(CWID), .SCREEN_WIDTH(SW),
    .SCREEN_HEIGHT(SH), .FIFO_DEPTH(DEPTH)
  ) dut (
    .clk(clk), .reset_n(reset_n), .pix(bus), .clear_err(clear_err),
    .overflow_err(overflow_err), .sync_err(sync_err), .frame_count(frame_count)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  typedef struct packed {
    logic [CWID-1:0] c;
    logic            sof;
    logic            eol;
  } ent_t;

  ent_t          mq[$];
  ent_t          m_e;
  logic          m_in_ready = 1'b0;
  logic          m_ovf = 1'b0;
  logic          m_sync = 1'b0;
  logic [15:0]   m_fc = 16'd0;
  logic [DW-1:0] m_ex = '0;
  logic [DW-1:0] m_ey = '0;
  bit            m_rd, m_wr, m_drop, m_serr;

  // Reference: a queue of pending beats plus the raster rules applied to each accepted beat.
  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      mq.delete();
      m_in_ready = 1'b0;
      m_ovf = 1'b0;
      m_sync = 1'b0;
      m_fc = 16'd0;
      m_ex = '0;
      m_ey = '0;
    end else begin
      m_rd   = (mq.size() != 0) && bus.out_ready;
      m_wr   = bus.in_valid && ((mq.size() < DEPTH) || m_rd);
      m_drop = bus.in_valid && !m_wr;
      m_serr = 1'b0;
      if (m_rd) begin
        if (mq[0].sof) m_fc = m_fc + 16'd1;
        mq.delete(0);
      end
      if (m_wr) begin
        m_e.c   = bus.in_colour;
        m_e.sof = (bus.in_xpixel == 0) && (bus.in_ypixel == 0);
        m_e.eol = (bus.in_xpixel == SW - 1);
        mq.push_back(m_e);
        m_serr = (bus.in_xpixel != m_ex) || (bus.in_ypixel != m_ey);
        if (bus.in_xpixel == SW - 1) begin
          m_ex = '0;
          m_ey = (bus.in_ypixel >= SH - 1) ? '0 : bus.in_ypixel + 1;
        end else begin
          m_ex = bus.in_xpixel + 1;
          m_ey = bus.in_ypixel;
        end
      end
      if (clear_err) begin
        m_ovf = 1'b0;
        m_sync = 1'b0;
      end
      if (m_drop) m_ovf = 1'b1;
      if (m_serr) m_sync = 1'b1;
      m_in_ready = (mq.size() <= DEPTH - 2);
    end
  end

  int hs_cnt = 0;
  int sof_cnt = 0;
  int eol_cnt = 0;
  int bad_seen = 0;

  always @(negedge clk) begin
    chk("out_valid", bus.out_valid, mq.size() != 0);
    chk("in_ready", bus.in_ready, m_in_ready);
    chk("overflow_err", overflow_err, m_ovf);
    chk("sync_err", sync_err, m_sync);
    chk("frame_count", frame_count, m_fc);
    if (mq.size() != 0) begin
      chk("out_data", bus.out_data, mq[0].c);
      chk("out_sof", bus.out_sof, mq[0].sof);
      chk("out_eol", bus.out_eol, mq[0].eol);
    end else begin
      chk("idle_out", {bus.out_data, bus.out_sof, bus.out_eol}, '0);
    end
    if (bus.out_valid && bus.out_ready) begin
      hs_cnt++;
      if (bus.out_sof) sof_cnt++;
      if (bus.out_eol) eol_cnt++;
      if (bus.out_data == 24'hBADBAD) bad_seen++;
    end
  end

  task automatic drive(input bit v, input int x, input int y, input logic [CWID-1:0] c,
                       input bit ordy, input bit clr);
    bus.in_valid  = v;
    bus.in_xpixel = x;
    bus.in_ypixel = y;
    bus.in_colour = c;
    bus.out_ready = ordy;
    clear_err     = clr;
  endtask

  task automatic cyc();
    @(posedge clk);
    #2;
  endtask

  int  gx, gy;
  bit  v, prev_rdy;

  initial begin
    drive(0, 0, 0, '0, 0, 0);
    reset_n = 1'b0;
    repeat (3) cyc();
    chk("rst_out_valid", bus.out_valid, 0);
    chk("rst_in_ready", bus.in_ready, 0);
    chk("rst_frame_count", frame_count, 0);
    chk("rst_errs", {overflow_err, sync_err}, 0);
    reset_n = 1'b1;
    chk("in_ready_before_edge", bus.in_ready, 0);
    cyc();
    chk("in_ready_after_release", bus.in_ready, 1);

    for (int i = 0; i < 4; i++) begin
      drive(1, i, 0, 24'h100 + 24'(i), 0, 0);
      cyc();
      if (i == 1) chk("bp_ready_cnt2", bus.in_ready, 1);
      if (i == 2) chk("bp_ready_cnt3", bus.in_ready, 0);
    end
    chk("bp_full_valid", bus.out_valid, 1);
    chk("bp_no_overflow", overflow_err, 0);
    chk("bp_head_data", bus.out_data, 24'h100);
    chk("bp_head_sof", bus.out_sof, 1);
    drive(0, 0, 0, '0, 1, 0);
    repeat (4) cyc();
    chk("bp_drained", bus.out_valid, 0);
    chk("bp_frame_count", frame_count, 1);

    for (int i = 0; i < 4; i++) begin
      drive(1, 4 + i, 0, 24'h200 + 24'(i), 0, 0);
      cyc();
    end
    drive(1, 8, 0, 24'hBADBAD, 0, 0);
    cyc();
    chk("ovf_set", overflow_err, 1);
    chk("ovf_head_kept", bus.out_data, 24'h200);
    drive(0, 0, 0, '0, 0, 1);
    cyc();
    chk("ovf_cleared", overflow_err, 0);
    drive(0, 0, 0, '0, 1, 0);
    repeat (4) cyc();
    chk("ovf_dropped_unseen", bad_seen, 0);

    for (int i = 0; i < 4; i++) begin
      drive(1, 8 + i, 0, 24'h300 + 24'(i), 0, 0);
      cyc();
    end
    drive(1, 12, 0, 24'h304, 1, 0);
    cyc();
    chk("rw_full_no_ovf", overflow_err, 0);
    chk("rw_full_head", bus.out_data, 24'h301);
    drive(0, 0, 0, '0, 1, 0);
    repeat (4) cyc();
    chk("rw_drained", bus.out_valid, 0);
    chk("rw_no_sync", sync_err, 0);

    drive(1, 5, 0, 24'h400, 1, 0);
    cyc();
    drive(0, 0, 0, '0, 1, 1);
    cyc();
    chk("disc_clear", sync_err, 0);
    drive(1, 7, 0, 24'h401, 1, 0);
    cyc();
    chk("disc_gap", sync_err, 1);
    drive(0, 0, 0, '0, 1, 1);
    cyc();
    drive(1, 8, 0, 24'h402, 1, 0);
    cyc();
    chk("disc_resync", sync_err, 0);
    drive(0, 0, 0, '0, 1, 0);
    cyc();
    drive(1, SW - 1, SH - 1, 24'h403, 0, 0);
    cyc();
    chk("corner_eol", bus.out_eol, 1);
    chk("corner_sof", bus.out_sof, 0);
    drive(0, 0, 0, '0, 1, 1);
    cyc();
    drive(1, 0, 0, 24'h404, 1, 0);
    cyc();
    chk("corner_wrap", sync_err, 0);
    drive(0, 0, 0, '0, 1, 0);
    cyc();
    chk("frame_count_two", frame_count, 2);

    for (int i = 0; i < 3; i++) begin
      drive(1, 1 + i, 0, 24'h500 + 24'(i), 0, 0);
      cyc();
    end
    drive(0, 0, 0, '0, 0, 0);
    chk("ar_buffered", bus.out_valid, 1);
    reset_n = 1'b0;
    #1;
    chk("ar_out_valid", bus.out_valid, 0);
    chk("ar_in_ready", bus.in_ready, 0);
    chk("ar_frame_count", frame_count, 0);
    cyc();
    reset_n = 1'b1;
    cyc();
    chk("ar_ready_back", bus.in_ready, 1);

    hs_cnt = 0;
    sof_cnt = 0;
    eol_cnt = 0;
    for (int y = 0; y < SH; y++) begin
      for (int x = 0; x < SW; x++) begin
        drive(1, x, y, 24'h10000 + 24'(y * SW + x), 1, 0);
        cyc();
      end
    end
    drive(0, 0, 0, '0, 1, 0);
    repeat (3) cyc();
    chk("raster_beats", hs_cnt, SW * SH);
    chk("raster_sof", sof_cnt, 1);
    chk("raster_eol", eol_cnt, SH);
    chk("raster_frames", frame_count, 1);
    chk("raster_errs", {overflow_err, sync_err}, 0);

    gx = 0;
    gy = 0;
    prev_rdy = 1'b1;
    for (int n = 0; n < 3000; n++) begin
      v = (prev_rdy && ($urandom_range(0, 3) != 0)) || ($urandom_range(0, 29) == 0);
      if (v && $urandom_range(0, 63) == 0) gx = $urandom_range(0, SW - 1);
      drive(v, gx, gy, 24'($urandom), $urandom_range(0, 9) < 7, $urandom_range(0, 39) == 0);
      prev_rdy = bus.in_ready;
      cyc();
      if (v) begin
        if (gx == SW - 1) begin
          gx = 0;
          gy = (gy >= SH - 1) ? 0 : gy + 1;
        end else begin
          gx = gx + 1;
        end
      end
    end
    drive(0, 0, 0, '0, 1, 0);
    repeat (8) cyc();
    chk("final_empty", bus.out_valid, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/pixel_stream_packer.md
Name: pixel_stream_packer

Overview:
- Downstream stage of the pixel coordinate/colour generator. Accepts one pixel per beat: x, y and colour, qualified by valid.
- Buffers beats in a small FIFO and re-emits them as a video stream with start-of-frame (sof) and end-of-line (eol) markers for the video output sink.
- Drives the upstream ready with one slot of slack, because the generator registers its output one cycle after sampling ready.
- Checks raster continuity and reports sticky errors.

Parameters:
- DATA_WIDTH, 32, width of the incoming x/y coordinates.
- RBG_SIZE, 24, colour width.
- SCREEN_WIDTH, 640, pixels per line.
- SCREEN_HEIGHT, 480, lines per frame.
- FIFO_DEPTH, 4, number of buffer entries; must be a power of 2 and at least 4.

Ports:
- clk  in  1  clock.
- reset_n  in  1  asynchronous active-low reset.
- in_valid  in  1  upstream beat valid.
- in_xpixel  in  DATA_WIDTH  pixel x coordinate.
- in_ypixel  in  DATA_WIDTH  pixel y coordinate.
- in_colour  in  RBG_SIZE  pixel colour.
- in_ready  out  1  to upstream ready/en.
- out_data  out  RBG_SIZE  colour of the head entry.
- out_sof  out  1  head entry is pixel (0,0).
- out_eol  out  1  head entry x == SCREEN_WIDTH-1.
- out_valid  out  1  FIFO not empty.
- out_ready  in  1  sink accepts the head entry.
- clear_err  in  1  synchronous clear of sticky errors.
- overflow_err  out  1  sticky: a beat was dropped.
- sync_err  out  1  sticky: coordinate discontinuity.
- frame_count  out  16  frames emitted (sof beats consumed at the output).

Behaviour:
- Reset (reset_n low, asynchronous):
  - FIFO empty: count=0, read and write pointers 0.
  - out_valid=0, in_ready=0.
  - overflow_err=0, sync_err=0, frame_count=0.
  - Expected coordinates: exp_x=0, exp_y=0.
  - out_data, out_sof and out_eol are 0 while the FIFO is empty.
- Reset release: in_ready rises on the first clk edge after reset_n goes high.
- in_ready:
  - Registered; in_ready = (count_next <= FIFO_DEPTH-2).
  - Guarantees one free slot for the beat the upstream stage already has in flight.
- Write:
  - A beat is written whenever in_valid=1 and the FIFO is not full, regardless of in_ready.
  - The write stores {colour, sof=(x==0 && y==0), eol=(x==SCREEN_WIDTH-1)}.
  - If in_valid=1 and the FIFO is full while no read happens in the same cycle, the beat is dropped and overflow_err is set.
- Read:
  - A handshake occurs when out_valid && out_ready; the head entry is popped.
  - out_data, out_sof and out_eol reflect the head entry combinationally from FIFO storage.
  - out_valid = (count != 0).
- Simultaneous write and read:
  - count is unchanged.
  - When full, the read frees a slot, so the write is accepted (no drop).
- Latency: a beat written at edge N is visible at the output after edge N; minimum latency is 1 cycle.
- Output ordering: out_data, out_sof and out_eol hold stable while out_valid=1 and out_ready=0.
- Continuity checker, on each accepted write:
  - If (x,y) != (exp_x,exp_y), set sync_err.
  - Then always resynchronise from the received coordinate:
    - If x == SCREEN_WIDTH-1: exp_x=0 and exp_y = (y >= SCREEN_HEIGHT-1) ? 0 : y+1.
    - Otherwise: exp_x=x+1, exp_y=y.
  - Any y >= SCREEN_HEIGHT-1 at end of line wraps exp_y to 0.
- frame_count:
  - Increments on each output handshake with out_sof=1.
  - Wraps modulo 2^16.
- clear_err:
  - Clears overflow_err and sync_err at the next edge.
  - If an error event occurs in the same cycle, set wins.
- Reset mid-frame: all buffered beats are discarded, and the checker again expects (0,0).
- Comparisons: coordinates are compared at full DATA_WIDTH. No truncation; no arithmetic overflow is possible within the screen bounds.

Test Plan:
- Reset-release smoke test:
  - Stimulus: release reset, out_ready=1, drive a full 640x480 raster from (0,0).
  - Required response: 307200 beats out, colours in order; exactly 1 sof (first beat) and 480 eol; frame_count=1; both error flags 0.
- Backpressure fill:
  - Stimulus: out_ready=0, in_valid held high.
  - Required response: in_ready drops once count reaches FIFO_DEPTH-1; the in-flight beat is still written (count=4); no overflow_err.
  - Then out_ready=1: 4 beats drain in order.
- Overflow:
  - Stimulus: FIFO full, out_ready=0, one extra in_valid beat.
  - Required response: overflow_err=1, count stays 4, the dropped colour never appears at the output.
  - Then clear_err pulse: overflow_err=0.
- Full with simultaneous read and write:
  - Stimulus: full FIFO, out_ready=1 and in_valid=1 in the same cycle.
  - Required response: count stays 4, overflow_err stays 0, order preserved.
- Discontinuity:
  - Stimulus: (5,0) followed by (7,0).
  - Required response: sync_err=1; a following beat (8,0) raises no further error condition.
  - Stimulus: (639,479).
  - Required response: eol=1, and the next expected coordinate is (0,0).
- Asynchronous reset mid-stream:
  - Stimulus: 3 beats buffered, pulse reset_n low between clock edges.
  - Required response: out_valid, in_ready and frame_count go to 0 immediately.
  - After release, a beat at (0,0) raises no sync_err.
